// File: rtl/font_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous-read font ROM among NREQ text generators.
// Optional output register stage enabled by defining FONT_ARB_OUTREG_EN (latency 2 instead of 1).
module font_rom_arbiter #(
    parameter int NREQ   = 4,
    parameter int ID_W   = 2,
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    output logic [NREQ-1:0]          gnt,
    output logic [ADDR_W-1:0]        rom_addr,
    input  logic [DATA_W-1:0]        rom_data,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [DATA_W-1:0]        rsp_data
);

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   win_id;
    logic              win_found;
    logic              grant;
    logic [ID_W-1:0]   next_ptr;
    logic [ADDR_W-1:0] last_addr;
    logic              rsp_valid_q;
    logic [ID_W-1:0]   rsp_id_q;

    // Scan requesters starting at rr_ptr and wrapping; the first set bit wins.
    always_comb begin
        int idx;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            // NOTE: blocking assignments here build a priority chain; win_found stops later hits.
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = ID_W'(idx);
            end
        end
    end

    // No grant is issued while reset is held, so no requester believes a discarded lookup was served.
    assign grant    = win_found && !reset;
    assign next_ptr = (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;

    always_comb begin
        gnt = '0;
        if (grant)
            gnt[win_id] = 1'b1;
    end

    assign rom_addr = grant ? req_addr[win_id*ADDR_W +: ADDR_W] : last_addr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            last_addr   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
        end else begin
            rsp_valid_q <= grant;
            if (grant) begin
                rr_ptr    <= next_ptr;
                last_addr <= rom_addr;
                rsp_id_q  <= win_id;
            end
        end
    end

`ifdef FONT_ARB_OUTREG_EN
    logic              out_valid;
    logic [ID_W-1:0]   out_id;
    logic [DATA_W-1:0] out_data;

    // rom_data is valid in the cycle after the lookup, so this stage lands at T+2.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_id    <= '0;
            out_data  <= '0;
        end else begin
            out_valid <= rsp_valid_q;
            out_id    <= rsp_id_q;
            out_data  <= rom_data;
        end
    end

    assign rsp_valid = out_valid;
    assign rsp_id    = out_id;
    assign rsp_data  = out_data;
`else
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rom_data;
`endif

endmodule
